// File: rtl/card_gfx_pkg.sv
// Shared types and constants for the card bitmap read path.
// Pixel bundle, tag carried alongside RAM reads, and reader FSM states.
package card_gfx_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 3;
   localparam int DIM_W  = 8;
   localparam int STRIDE = 111;
   localparam int CARD_H = 135;

   localparam logic [DATA_W-1:0] TRANSPARENT = 3'b000;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [DIM_W-1:0]  x;
      logic [DIM_W-1:0]  y;
      logic              last;
   } pix_t;

   typedef struct packed {
      logic [DIM_W-1:0] x;
      logic [DIM_W-1:0] y;
      logic             last;
   } pix_tag_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/card_pix_fifo2.sv
// Two-entry pixel FIFO; push and pop may coincide even when full.
// Head is always the oldest entry; count tells the consumer if it is live.
module card_pix_fifo2
   import card_gfx_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push,
   input  pix_t       push_data,
   input  logic       pop,
   output pix_t       head,
   output logic [1:0] count
);

   pix_t       slot0_q, slot0_d;
   pix_t       slot1_q, slot1_d;
   logic       wr_q, wr_d;
   logic       rd_q, rd_d;
   logic [1:0] cnt_q, cnt_d;
   logic       do_push;
   logic       do_pop;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      do_pop  = pop && (cnt_q != 2'd0);
      do_push = push && ((cnt_q != 2'd2) || do_pop);
      if (do_push) begin
         if (wr_q) begin
            slot1_d = push_data;
         end else begin
            slot0_d = push_data;
         end
         wr_d = ~wr_q;
      end
      if (do_pop) begin
         rd_d = ~rd_q;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign head  = rd_q ? slot1_q : slot0_q;
   assign count = cnt_q;

endmodule

// File: rtl/card_sprite_reader.sv
// Streams a rectangular region of the card bitmap RAM out as pixels.
// One read per cycle, throttled so returning data always fits the buffer.
module card_sprite_reader
   import card_gfx_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   output logic              busy,
   output logic              done,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic [DIM_W-1:0]  pix_x,
   output logic [DIM_W-1:0]  pix_y,
   output logic              pix_opaque,
   output logic              pix_last
);

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [DIM_W-1:0]  col_q, col_d;
   logic [DIM_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] col_addr_q, col_addr_d;
   logic              inflight_q, inflight_d;
   pix_tag_t          tag_q, tag_d;

   pix_t              fifo_in;
   pix_t              head;
   logic [1:0]        count;
   logic              pop;
   logic [2:0]        occ;
   logic              last_col;
   logic              last_row;
   logic [ADDR_W-1:0] next_row_base;

   assign pop       = pix_valid && pix_ready;
   assign last_col  = (col_q == width_q - 1'b1);
   assign last_row  = (row_q == height_q - 1'b1);
   assign next_row_base = row_base_q + ADDR_W'(STRIDE);
   // Slots that will be taken after this edge if no new read is issued.
   assign occ = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};

   assign fifo_in = '{data: mem_data, x: tag_q.x,
                      y: tag_q.y, last: tag_q.last};

   card_pix_fifo2 u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (inflight_q),
      .push_data (fifo_in),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (width == '0 || height == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (mem_re && last_col && last_row) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (count == 2'd0 && !inflight_q) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q == RUN) || (state_q == DRAIN);
      done     = (state_q == DONE);
      mem_re   = (state_q == RUN) && (occ < 3'd2);
      mem_addr = col_addr_q;
   end

   always_comb begin
      width_d    = width_q;
      height_d   = height_q;
      col_d      = col_q;
      row_d      = row_q;
      row_base_d = row_base_q;
      col_addr_d = col_addr_q;
      inflight_d = mem_re;
      tag_d      = tag_q;
      if (state_q == IDLE && start) begin
         width_d    = width;
         height_d   = height;
         col_d      = '0;
         row_d      = '0;
         row_base_d = base_addr;
         col_addr_d = base_addr;
      end
      if (mem_re) begin
         tag_d = '{x: col_q, y: row_q, last: last_col && last_row};
         if (last_col) begin
            col_d      = '0;
            row_d      = row_q + 1'b1;
            row_base_d = next_row_base;
            col_addr_d = next_row_base;
         end else begin
            col_d      = col_q + 1'b1;
            col_addr_d = col_addr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         width_q    <= '0;
         height_q   <= '0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         col_addr_q <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         width_q    <= width_d;
         height_q   <= height_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_base_q <= row_base_d;
         col_addr_q <= col_addr_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
      end
   end

   assign pix_valid  = (count != 2'd0);
   assign pix_data   = pix_valid ? head.data : '0;
   assign pix_x      = pix_valid ? head.x : '0;
   assign pix_y      = pix_valid ? head.y : '0;
   assign pix_last   = pix_valid && head.last;
   assign pix_opaque = pix_valid && (head.data != TRANSPARENT);

endmodule

// File: tb/tb_card_sprite_reader.sv
// Scoreboard bench for card_sprite_reader with a 1-cycle-latency RAM model.
// RAM content is RAM[n] = n[2:0].
module tb_card_sprite_reader;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] base_addr = '0;
   logic [7:0]  width = '0;
   logic [7:0]  height = '0;
   logic        busy;
   logic        done;
   logic        mem_re;
   logic [13:0] mem_addr;
   logic [2:0]  mem_data = '0;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic [2:0]  pix_data;
   logic [7:0]  pix_x;
   logic [7:0]  pix_y;
   logic        pix_opaque;
   logic        pix_last;

   int vecs = 0;
   int errs = 0;

   logic [19:0] exp_q[$];
   logic [13:0] addr_q[$];

   card_sprite_reader dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .width      (width),
      .height     (height),
      .busy       (busy),
      .done       (done),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_opaque (pix_opaque),
      .pix_last   (pix_last)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_re) mem_data <= mem_addr[2:0];
   end

   function automatic logic ready_of(input int mode, input int cyc);
      case (mode)
         1: return cyc[0];
         2: return !(cyc >= 6 && cyc < 11);
         default: return 1'b1;
      endcase
   endfunction

   task automatic run_region(input logic [13:0] b, input logic [7:0] w,
                             input logic [7:0] h, input int mode,
                             input bit restart);
      int          cyc;
      int          first_v;
      int          last_hs;
      int          done_cyc;
      int          n_done;
      int          out_n;
      bit          stall;
      logic [20:0] held;
      logic [20:0] now_v;
      logic [19:0] e;
      logic [13:0] a;
      logic [13:0] ea;
      exp_q.delete();
      addr_q.delete();
      for (int y = 0; y < int'(h); y++) begin
         for (int x = 0; x < int'(w); x++) begin
            a = b + 14'(y * 111 + x);
            addr_q.push_back(a);
            exp_q.push_back({a[2:0], 8'(x), 8'(y),
                             (x == int'(w) - 1) && (y == int'(h) - 1)});
         end
      end
      @(negedge clock);
      base_addr = b; width = w; height = h; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1; first_v = -1; last_hs = -1; done_cyc = -1;
      n_done = 0; out_n = 0; stall = 1'b0; held = '0;
      while (cyc < 300) begin
         pix_ready = ready_of(mode, cyc);
         if (restart && cyc == 4) begin
            start = 1'b1; base_addr = 14'd500; width = 8'd9; height = 8'd9;
         end else begin
            start = 1'b0;
         end
         #1;
         now_v = {pix_valid, pix_data, pix_x, pix_y, pix_last};
         if (stall) begin
            vecs++;
            if (now_v !== held) begin
               errs++;
               $display("FAIL stable c%0d: got %h want %h", cyc, now_v, held);
            end
         end
         if (pix_valid && first_v < 0) first_v = cyc;
         if (!done && (w != 0) && (h != 0)) begin
            vecs++;
            if (busy !== 1'b1) begin
               errs++;
               $display("FAIL busy c%0d: got %b want 1", cyc, busy);
            end
         end
         if (mem_re) begin
            out_n++;
            vecs++;
            if (addr_q.size() == 0) begin
               errs++;
               $display("FAIL extra_read c%0d: got addr %0d want none", cyc, mem_addr);
            end else begin
               ea = addr_q.pop_front();
               if (mem_addr !== ea) begin
                  errs++;
                  $display("FAIL mem_addr c%0d: got %0d want %0d", cyc, mem_addr, ea);
               end
            end
         end
         if (pix_valid && pix_ready) begin
            out_n--;
            last_hs = cyc;
            vecs++;
            if (exp_q.size() == 0) begin
               errs++;
               $display("FAIL extra_pix c%0d: got %h want none", cyc, now_v);
            end else begin
               e = exp_q.pop_front();
               if ({pix_data, pix_x, pix_y, pix_last} !== e) begin
                  errs++;
                  $display("FAIL pixel c%0d: got %h want %h", cyc,
                           {pix_data, pix_x, pix_y, pix_last}, e);
               end
               vecs++;
               if (pix_opaque !== (e[19:17] != 3'd0)) begin
                  errs++;
                  $display("FAIL opaque c%0d: got %b want %b", cyc, pix_opaque,
                           e[19:17] != 3'd0);
               end
            end
         end
         vecs++;
         if (out_n > 2) begin
            errs++;
            $display("FAIL outstanding c%0d: got %0d want <=2", cyc, out_n);
         end
         stall = pix_valid && !pix_ready;
         held = now_v;
         if (done) begin
            n_done++;
            done_cyc = cyc;
            vecs++;
            if (busy !== 1'b0) begin
               errs++;
               $display("FAIL busy_at_done: got %b want 0", busy);
            end
            break;
         end
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      vecs++;
      if (n_done != 1) begin
         errs++;
         $display("FAIL done_seen: got %0d want 1 (timeout)", n_done);
      end
      vecs++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
         errs++;
         $display("FAIL leftover: got %0d pix %0d addr want 0",
                  exp_q.size(), addr_q.size());
      end
      if (w == 0 || h == 0) begin
         vecs++;
         if (done_cyc != 1 || first_v != -1) begin
            errs++;
            $display("FAIL zero_size: got done c%0d valid c%0d want 1 -1",
                     done_cyc, first_v);
         end
      end else begin
         vecs++;
         if (first_v != 3) begin
            errs++;
            $display("FAIL first_valid: got c%0d want c3", first_v);
         end
         vecs++;
         if (done_cyc != last_hs + 2) begin
            errs++;
            $display("FAIL done_time: got c%0d want c%0d", done_cyc, last_hs + 2);
         end
      end
      @(negedge clock);
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL done_pulse: got done %b busy %b want 0 0", done, busy);
      end
   endtask

   task automatic test_reset;
      #2;
      vecs++;
      if ({busy, done, mem_re, mem_addr, pix_valid, pix_data, pix_x, pix_y,
           pix_opaque, pix_last} !== '0) begin
         errs++;
         $display("FAIL reset_outs: got %b %b %b %0d %b want all 0",
                  busy, done, mem_re, mem_addr, pix_valid);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      vecs++;
      if ({busy, done, mem_re, pix_valid} !== 4'b0) begin
         errs++;
         $display("FAIL idle_outs: got %b want 0000", {busy, done, mem_re, pix_valid});
      end
   endtask

   task automatic test_basic;
      run_region(14'd0, 8'd4, 8'd2, 0, 1'b0);
   endtask

   task automatic test_toggle;
      run_region(14'd0, 8'd4, 8'd2, 1, 1'b0);
   endtask

   task automatic test_stall;
      run_region(14'd0, 8'd4, 8'd2, 2, 1'b0);
   endtask

   task automatic test_zero;
      run_region(14'd0, 8'd0, 8'd5, 0, 1'b0);
      run_region(14'd0, 8'd3, 8'd0, 0, 1'b0);
   endtask

   task automatic test_wrap;
      run_region(14'd16380, 8'd6, 8'd1, 0, 1'b0);
      run_region(14'd16300, 8'd3, 8'd3, 1, 1'b0);
   endtask

   task automatic test_opaque;
      run_region(14'd0, 8'd6, 8'd1, 0, 1'b0);
   endtask

   task automatic test_ignore_start;
      run_region(14'd0, 8'd4, 8'd2, 0, 1'b1);
   endtask

   task automatic test_reset_mid;
      int dn;
      @(negedge clock);
      base_addr = 14'd0; width = 8'd8; height = 8'd4;
      start = 1'b1; pix_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      vecs++;
      if ({busy, mem_re, pix_valid} !== 3'b111) begin
         errs++;
         $display("FAIL mid_run: got %b want 111", {busy, mem_re, pix_valid});
      end
      #2;
      reset_n = 1'b0;
      #1;
      vecs++;
      if ({busy, mem_re, pix_valid, done} !== 4'b0) begin
         errs++;
         $display("FAIL async_reset: got %b want 0000", {busy, mem_re, pix_valid, done});
      end
      dn = 0;
      repeat (3) begin
         @(negedge clock);
         if (done) dn++;
      end
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (done || busy) dn++;
      end
      vecs++;
      if (dn != 0) begin
         errs++;
         $display("FAIL no_done_after_reset: got %0d want 0", dn);
      end
   endtask

   task automatic test_after_reset;
      run_region(14'd37, 8'd5, 8'd3, 1, 1'b0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_toggle;
      test_stall;
      test_zero;
      test_wrap;
      test_opaque;
      test_ignore_start;
      test_reset_mid;
      test_after_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
